// File: rtl/note_seq.sv
// Score sequencer: fetches 16-bit note entries and drives the tone divider and beat counter; NOTE_SEQ_LOOP_EN repeats the score.
// Latency: start -> rom_rd next cycle -> tone valid 3 cycles after start is sampled; beat period beat_len+2, note gap 2 cycles.
// Backpressure: none; ROM answers the cycle after rom_rd, beat_finish paces each beat, stop aborts from any state.
module note_seq #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stop,
    input  logic [27:0]       beat_len,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic              beat_finish,
    output logic [27:0]       beat_cnt_parameter,
    output logic              beat_en,
    output logic              beat_rstn,
    output logic [4:0]        tone_idx,
    output logic              tone_en,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_PLAY  = 2'd3;

    logic [1:0]  state;
    logic [2:0]  beats_left;
    logic [4:0]  entry_pitch;
    logic [2:0]  entry_dur;
    logic [27:0] beat_len_eff;
    logic        unused_reserved;

    assign entry_pitch     = rom_data[15:11];
    assign entry_dur       = rom_data[10:8];
    assign unused_reserved = ^rom_data[7:0];

    // A zero tempo would never let the counter finish, so it runs as one.
    assign beat_len_eff = (beat_len == '0) ? 28'd1 : beat_len;

    assign rom_rd  = (state == S_FETCH);
    assign beat_en = (state == S_PLAY);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state              <= S_IDLE;
            rom_addr           <= '0;
            beats_left         <= 3'd0;
            beat_cnt_parameter <= 28'd1;
            beat_rstn          <= 1'b0;
            tone_idx           <= 5'd0;
            tone_en            <= 1'b0;
            done               <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state     <= S_IDLE;
                rom_addr  <= '0;
                tone_en   <= 1'b0;
                beat_rstn <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state    <= S_FETCH;
                            rom_addr <= '0;
                        end
                    end
                    S_FETCH: begin
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (entry_dur == 3'd0) begin
                            done     <= 1'b1;
                            rom_addr <= '0;
`ifdef NOTE_SEQ_LOOP_EN
                            state    <= S_FETCH;
`else
                            state    <= S_IDLE;
                            tone_en  <= 1'b0;
`endif
                        end else begin
                            state              <= S_PLAY;
                            tone_idx           <= entry_pitch;
                            tone_en            <= (entry_pitch != 5'd0);
                            beats_left         <= entry_dur;
                            beat_rstn          <= 1'b0;
                            beat_cnt_parameter <= beat_len_eff;
                        end
                    end
                    S_PLAY: begin
                        // beat_rstn low marks the restart cycle; a finish seen then belongs to the old beat.
                        if (!beat_rstn) begin
                            beat_rstn <= 1'b1;
                        end else if (beat_finish) begin
                            beat_rstn <= 1'b0;
                            if (beats_left > 3'd1) begin
                                beats_left         <= beats_left - 3'd1;
                                beat_cnt_parameter <= beat_len_eff;
                            end else begin
                                state    <= S_FETCH;
                                rom_addr <= rom_addr + ADDR_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_seq.sv
// Bench for note_seq: expected per-cycle output timelines are built from the score rules and compared every cycle.
module tb_note_seq;
    localparam int AW   = 2;
    localparam int CAP  = 200;
    localparam int LOGN = 512;

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic          en;
        logic          brst;
        logic          ten;
        logic [4:0]    tidx;
        logic          busy;
        logic          done;
        logic [27:0]   param;
    } obs_t;

    logic          clk, rstn, start, stop;
    logic [27:0]   beat_len;
    logic          rom_rd;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic          beat_finish;
    logic [27:0]   beat_cnt_parameter;
    logic          beat_en, beat_rstn;
    logic [4:0]    tone_idx;
    logic          tone_en, busy, done;

    note_seq #(.ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .beat_len(beat_len),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data), .beat_finish(beat_finish),
        .beat_cnt_parameter(beat_cnt_parameter), .beat_en(beat_en), .beat_rstn(beat_rstn),
        .tone_idx(tone_idx), .tone_en(tone_en), .busy(busy), .done(done)
    );

    logic [15:0] rom [0:(1<<AW)-1];
    int          cyc;
    int          n_pass, n_total;
    bit          chk_en;
    int          exp_stamp[$];
    obs_t        exp_obs[$];
    obs_t        log_o [0:LOGN-1];
    logic [27:0] last_param;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.rd = rom_rd; o.addr = rom_addr; o.en = beat_en; o.brst = beat_rstn; o.ten = tone_en;
        o.tidx = tone_idx; o.busy = busy; o.done = done; o.param = beat_cnt_parameter;
        return o;
    endfunction

    function automatic obs_t mk(logic rd, logic [AW-1:0] a, logic en, logic brst, logic ten,
                                logic [4:0] ti, logic bsy, logic dn, logic [27:0] p);
        obs_t o;
        o.rd = rd; o.addr = a; o.en = en; o.brst = brst; o.ten = ten;
        o.tidx = ti; o.busy = bsy; o.done = dn; o.param = p;
        return o;
    endfunction

    // Timeline per played note: FETCH, WAIT, then d beats of (restart + beat_len+1) cycles.
    task automatic gen(input int base, input int L, input int stop_req, output int stop_rel, output int len);
        obs_t          tl[$];
        logic [AW-1:0] a = '0;
        logic          ten = 1'b0;
        logic [4:0]    ti = 5'd0;
        logic [27:0]   p = last_param;
        logic [27:0]   leff = (L == 0) ? 28'd1 : 28'(L);
        int            per = int'(leff) + 2;
        bit            ended = 1'b0;
        logic          dflag = 1'b0;
        logic [15:0]   e;
        while (!ended && tl.size() < CAP) begin
            tl.push_back(mk(1'b1, a, 1'b0, 1'b0, ten, ti, 1'b1, dflag, p));
            dflag = 1'b0;
            tl.push_back(mk(1'b0, a, 1'b0, 1'b0, ten, ti, 1'b1, 1'b0, p));
            e = rom[a];
            if (e[10:8] == 3'd0) begin
`ifdef NOTE_SEQ_LOOP_EN
                a = '0;
                dflag = 1'b1;
`else
                tl.push_back(mk(1'b0, '0, 1'b0, 1'b0, 1'b0, ti, 1'b0, 1'b1, p));
                ended = 1'b1;
`endif
            end else begin
                ti = e[15:11];
                ten = (e[15:11] != 5'd0);
                p = leff;
                for (int b = 0; b < int'(e[10:8]); b++)
                    for (int j = 0; j < per; j++)
                        tl.push_back(mk(1'b0, a, 1'b1, (j != 0), ten, ti, 1'b1, 1'b0, p));
                a = a + AW'(1);
            end
        end
        stop_rel = stop_req;
        if (stop_rel == 0 && !ended) stop_rel = tl.size();
        if (stop_rel > 0 && (stop_rel < tl.size() || !ended)) begin
            p = tl[stop_rel-1].param;
            while (tl.size() > stop_rel) void'(tl.pop_back());
            tl.push_back(mk(1'b0, '0, 1'b0, 1'b0, 1'b0, ti, 1'b0, 1'b0, p));
        end
        last_param = tl[tl.size()-1].param;
        len = tl.size();
        foreach (tl[i]) begin
            exp_stamp.push_back(base + 1 + i);
            exp_obs.push_back(tl[i]);
        end
    endtask

    task automatic run(input int L, input int stop_req, input int sb);
        int base, srel, len, idx;
        int sbu = 0;
        @(negedge clk);
        beat_len = 28'(L);
        start = 1'b1;
        base = cyc;
        gen(base, L, stop_req, srel, len);
        idx = exp_obs.size() - len + sb - 1;
        if (sb > 0 && sb <= len && exp_obs[idx].busy && (srel == 0 || sb <= srel)) sbu = sb;
        for (int k = 1; k <= len + 4; k++) begin
            @(negedge clk);
            start = (k == sbu);
            stop  = (k == srel);
            if (k < LOGN) log_o[k] = sample();
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Every-cycle compare; cycles without a timeline entry must look idle.
    initial begin
        obs_t got, want;
        bit   full;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                got  = sample();
                want = mk(1'b0, '0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 28'd0);
                full = 1'b0;
                while (exp_stamp.size() > 0 && exp_stamp[0] < cyc) begin
                    void'(exp_stamp.pop_front());
                    void'(exp_obs.pop_front());
                end
                if (exp_stamp.size() > 0 && exp_stamp[0] == cyc) begin
                    void'(exp_stamp.pop_front());
                    want = exp_obs.pop_front();
                    full = 1'b1;
                end
                if (!full) got.param = 28'd0;
                if (!want.ten) begin
                    got.tidx  = 5'd0;
                    want.tidx = 5'd0;
                end
                check("outputs", 64'(got), 64'(want));
            end
        end
    end

    // Environment: score ROM with one-cycle read latency and a beat counter, plus stray finishes while cleared.
    initial begin
        int            cnt = 0;
        logic          p_rst = 1'b0, p_en = 1'b0, p_rd = 1'b0;
        logic [AW-1:0] p_a = '0;
        rom_data    = 16'h0;
        beat_finish = 1'b0;
        forever begin
            @(negedge clk);
            if (!p_rst) cnt = 0;
            else if (p_en) cnt++;
            beat_finish = (beat_en && beat_rstn && cnt == int'(beat_cnt_parameter)) ||
                          (!beat_rstn && $urandom_range(0, 1) == 1);
            rom_data = p_rd ? rom[p_a] : 16'($urandom);
            p_rst = beat_rstn;
            p_en  = beat_en;
            p_rd  = rom_rd;
            p_a   = rom_addr;
        end
    end

    initial begin
        int          nb, nrd;
        bit          anyt;
        int          L, sr, sb;
        logic [4:0]  pi;
        logic [2:0]  du;
        rstn = 1'b0; start = 1'b0; stop = 1'b0; beat_len = 28'd3;
        chk_en = 1'b0; n_pass = 0; n_total = 0; last_param = 28'd1;
        foreach (rom[i]) rom[i] = 16'h0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        chk_en = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_rom_rd", 64'(rom_rd), 64'(0));
        check("rst_rom_addr", 64'(rom_addr), 64'(0));
        check("rst_param", 64'(beat_cnt_parameter), 64'(1));
        check("rst_beat_en", 64'(beat_en), 64'(0));
        check("rst_beat_rstn", 64'(beat_rstn), 64'(0));
        check("rst_tone_idx", 64'(tone_idx), 64'(0));
        check("rst_tone_en", 64'(tone_en), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));

        // Pitch 5 for 2 beats at beat_len 3: PLAY cycles 3..12, refetch 13, end marker done at 15.
        rom[0] = 16'h2A00; rom[1] = 16'h0000;
        run(3, 0, 0);
        check("s1_tone_en_pre", 64'(log_o[2].ten), 64'(0));
        check("s1_tone_en", 64'(log_o[3].ten), 64'(1));
        check("s1_tone_idx", 64'(log_o[3].tidx), 64'(5));
        check("s1_param", 64'(log_o[3].param), 64'(3));
        check("s1_no_early_rd", 64'(log_o[12].rd), 64'(0));
        check("s1_refetch", 64'(log_o[13].rd), 64'(1));
        check("s1_done", 64'(log_o[15].done), 64'(1));

        rom[0] = 16'h0100;
        run(3, 0, 0);
        nb = 0; nrd = 0; anyt = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (log_o[k].rd) nrd++;
            if (log_o[k].busy && nrd < 2) nb++;
            if (log_o[k].ten) anyt = 1'b1;
        end
        check("rest_busy_cycles", 64'(nb), 64'(7));
        check("rest_silent", 64'(anyt), 64'(0));

        rom[0] = 16'h3F00;
        run(2, 20, 0);
        check("stop_pre_busy", 64'(log_o[20].busy), 64'(1));
        check("stop_pre_tone", 64'(log_o[20].ten), 64'(1));
        check("stop_tone_en", 64'(log_o[21].ten), 64'(0));
        check("stop_addr", 64'(log_o[21].addr), 64'(0));
        check("stop_busy", 64'(log_o[21].busy), 64'(0));
        check("stop_no_done", 64'(log_o[21].done), 64'(0));

        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", 64'(busy), 64'(0));
        check("startstop_rd", 64'(rom_rd), 64'(0));

        rom[0] = 16'h2A00; rom[1] = 16'h0000;
        run(3, 0, 6);
        check("busy_start_no_rd", 64'(log_o[7].rd), 64'(0));
        check("busy_start_addr", 64'(log_o[13].addr), 64'(1));

        foreach (rom[i]) rom[i] = 16'h0900;
        run(0, 24, 0);
        check("wrap_addr3", 64'(log_o[16].addr), 64'(3));
        check("wrap_addr0", 64'(log_o[21].addr), 64'(0));
        check("wrap_rd", 64'(log_o[21].rd), 64'(1));

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < (1 << AW); i++) begin
                pi = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                du = ($urandom_range(0, 4) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
                rom[i] = {pi, du, 8'($urandom)};
            end
            L  = int'($urandom_range(0, 4));
            sr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : 0;
            sb = ($urandom_range(0, 1) == 0) ? int'($urandom_range(2, 8)) : 0;
            run(L, sr, sb);
        end

        rom[0] = 16'h3F00; rom[1] = 16'h0000;
        chk_en = 1'b0;
        @(negedge clk);
        beat_len = 28'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("arst_pre_busy", 64'(busy), 64'(1));
        check("arst_pre_tone", 64'(tone_en), 64'(1));
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_rom_rd", 64'(rom_rd), 64'(0));
        check("arst_rom_addr", 64'(rom_addr), 64'(0));
        check("arst_param", 64'(beat_cnt_parameter), 64'(1));
        check("arst_beat_en", 64'(beat_en), 64'(0));
        check("arst_beat_rstn", 64'(beat_rstn), 64'(0));
        check("arst_tone_idx", 64'(tone_idx), 64'(0));
        check("arst_tone_en", 64'(tone_en), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(done), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
